// File: rtl/mem_responder.sv
// mem_responder: 256x8 memory serving panel program load (IN), panel
// readback (CHECK) and control-unit read/write traffic (RUN).
// The pointer and sticky flags are registered; dout and chk_data are
// combinational views of the array so the control unit can sample dout
// into DR on the next edge.
module mem_responder (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] cpustate,
  input  logic [7:0] addr,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] ld_data,
  input  logic       ld_strobe,
  input  logic       chk_step,
  output logic [7:0] ptr,
  output logic [7:0] chk_data,
  output logic       wrapped,
  output logic       conflict
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_IN    = 2'b01,
    ST_CHECK = 2'b10,
    ST_RUN   = 2'b11
  } cpu_state_e;

  cpu_state_e cur_state_s;
  assign cur_state_s = cpu_state_e'(cpustate);

  // Storage is deliberately left out of reset so a loaded program survives it.
  logic [7:0] mem [0:255];

  cpu_state_e state_prev_q, state_prev_d;
  logic [7:0] ptr_q, ptr_d;
  logic       wrapped_q, wrapped_d;
  logic       conflict_q, conflict_d;
  logic       ld_prev_q, ld_prev_d;
  logic       chk_prev_q, chk_prev_d;

  logic       state_change_s;
  logic       ld_rise_s;
  logic       chk_rise_s;
  logic       mem_we_s;
  logic [7:0] mem_waddr_s;
  logic [7:0] mem_wdata_s;

  // Edge detection: a strobe counts only when high now and low last cycle.
  always_comb begin
    state_change_s = (cur_state_s != state_prev_q);
    ld_rise_s      = ld_strobe & ~ld_prev_q;
    chk_rise_s     = chk_step & ~chk_prev_q;
  end

  // Next-state logic for pointer, sticky flags and memory write port.
  always_comb begin
    state_prev_d = cur_state_s;
    ld_prev_d    = ld_strobe;
    chk_prev_d   = chk_step;
    ptr_d        = ptr_q;
    wrapped_d    = wrapped_q;
    conflict_d   = conflict_q;
    mem_we_s     = 1'b0;
    mem_waddr_s  = ptr_q;
    mem_wdata_s  = ld_data;

    if (state_change_s) begin
      // A new session starts from address 0; strobe edges on this edge are dropped.
      ptr_d     = 8'h00;
      wrapped_d = 1'b0;
    end else begin
      case (cur_state_s)
        ST_IN: begin
          if (ld_rise_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = ptr_q;
            mem_wdata_s = ld_data;
            ptr_d       = ptr_q + 8'd1;
            if (ptr_q == 8'hFF) begin
              wrapped_d = 1'b1;
            end else begin
              wrapped_d = wrapped_q;
            end
          end else begin
            ptr_d = ptr_q;
          end
        end
        ST_CHECK: begin
          if (chk_rise_s) begin
            ptr_d = ptr_q + 8'd1;
            if (ptr_q == 8'hFF) begin
              wrapped_d = 1'b1;
            end else begin
              wrapped_d = wrapped_q;
            end
          end else begin
            ptr_d = ptr_q;
          end
        end
        ST_IDLE: ptr_d = ptr_q;
        ST_RUN:  ptr_d = ptr_q;
        default: ptr_d = ptr_q;
      endcase
    end

    // Control-unit traffic: simultaneous read and write keeps the read, drops the write.
    if (cur_state_s == ST_RUN) begin
      if (read && write) begin
        conflict_d = 1'b1;
      end else if (write) begin
        mem_we_s    = 1'b1;
        mem_waddr_s = addr;
        mem_wdata_s = din;
      end else begin
        conflict_d = conflict_q;
      end
    end else begin
      conflict_d = conflict_q;
    end
  end

  // Control registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_prev_q <= ST_IDLE;
      ptr_q        <= 8'h00;
      wrapped_q    <= 1'b0;
      conflict_q   <= 1'b0;
      ld_prev_q    <= 1'b0;
      chk_prev_q   <= 1'b0;
    end else begin
      state_prev_q <= state_prev_d;
      ptr_q        <= ptr_d;
      wrapped_q    <= wrapped_d;
      conflict_q   <= conflict_d;
      ld_prev_q    <= ld_prev_d;
      chk_prev_q   <= chk_prev_d;
    end
  end

  // Memory write port; blocked while reset is held so a pending byte is never stored.
  always_ff @(posedge clk) begin
    if (mem_we_s && rst) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Combinational read paths toward the bus and the panel.
  always_comb begin
    dout     = 8'h00;
    chk_data = mem[ptr_q];
    if ((cur_state_s == ST_RUN) && read) begin
      dout = mem[addr];
    end else begin
      dout = 8'h00;
    end
  end

  assign ptr      = ptr_q;
  assign wrapped  = wrapped_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder plus hand-written
// sequences for pointer wrap and reset-during-load.
module tb_mem_responder;

  logic       clk;
  logic       rst;
  logic [1:0] cpustate;
  logic [7:0] addr;
  logic       read;
  logic       write;
  logic [7:0] din;
  logic [7:0] dout;
  logic [7:0] ld_data;
  logic       ld_strobe;
  logic       chk_step;
  logic [7:0] ptr;
  logic [7:0] chk_data;
  logic       wrapped;
  logic       conflict;

  int n_checks;
  int n_pass;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_IN    = 2'b01;
  localparam logic [1:0] S_CHECK = 2'b10;
  localparam logic [1:0] S_RUN   = 2'b11;

  typedef struct {
    logic [1:0] cs;
    logic       ld;
    logic [7:0] ldd;
    logic       chk;
    logic       rd;
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp_dout;
    logic [7:0] exp_ptr;
    logic       exp_wrap;
    logic       exp_conf;
    logic       cd_en;
    logic [7:0] exp_cd;
  } vec_t;

  vec_t vq[$];

  mem_responder dut (
    .clk      (clk),
    .rst      (rst),
    .cpustate (cpustate),
    .addr     (addr),
    .read     (read),
    .write    (write),
    .din      (din),
    .dout     (dout),
    .ld_data  (ld_data),
    .ld_strobe(ld_strobe),
    .chk_step (chk_step),
    .ptr      (ptr),
    .chk_data (chk_data),
    .wrapped  (wrapped),
    .conflict (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [1:0] cs, input logic ld, input logic [7:0] ldd,
                              input logic chk, input logic rd, input logic wr,
                              input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] exp_dout, input logic [7:0] exp_ptr,
                              input logic exp_wrap, input logic exp_conf,
                              input logic cd_en, input logic [7:0] exp_cd);
    vec_t v;
    v.cs = cs; v.ld = ld; v.ldd = ldd; v.chk = chk; v.rd = rd; v.wr = wr;
    v.a = a; v.d = d; v.exp_dout = exp_dout; v.exp_ptr = exp_ptr;
    v.exp_wrap = exp_wrap; v.exp_conf = exp_conf; v.cd_en = cd_en; v.exp_cd = exp_cd;
    return v;
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", name, act, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_pulse(input logic [7:0] data);
    ld_data   = data;
    ld_strobe = 1'b1;
    step();
    ld_strobe = 1'b0;
    step();
  endtask

  task automatic chk_pulse();
    chk_step = 1'b1;
    step();
    chk_step = 1'b0;
    step();
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b0;
    cpustate  = S_IDLE;
    addr      = 8'h00;
    read      = 1'b0;
    write     = 1'b0;
    din       = 8'h00;
    ld_data   = 8'h00;
    ld_strobe = 1'b0;
    chk_step  = 1'b0;

    //      cs      ld    ldd    chk   rd    wr    addr   din    dout   ptr    wrap  conf  cd_en cd
    vq.push_back(mk(S_IN,    1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00));
    vq.push_back(mk(S_IN,    1'b1, 8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00));
    vq.push_back(mk(S_IN,    1'b0, 8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00));
    vq.push_back(mk(S_IN,    1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00));
    vq.push_back(mk(S_IN,    1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00));
    vq.push_back(mk(S_IN,    1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(S_IN,  1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00));
    vq.push_back(mk(S_IN,    1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00));
    vq.push_back(mk(S_CHECK, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'hE0));
    vq.push_back(mk(S_CHECK, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 8'h10));
    vq.push_back(mk(S_CHECK, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 8'h10));
    vq.push_back(mk(S_CHECK, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 8'h10));
    vq.push_back(mk(S_CHECK, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1, 8'hF0));
    vq.push_back(mk(S_CHECK, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1, 8'hF0));
    vq.push_back(mk(S_RUN,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'hE0));
    vq.push_back(mk(S_RUN,   1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h40, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'hE0));
    vq.push_back(mk(S_RUN,   1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1, 8'hE0));
    vq.push_back(mk(S_RUN,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h40, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'hE0));
    vq.push_back(mk(S_RUN,   1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h40, 8'hFF, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b1, 8'hE0));
    vq.push_back(mk(S_RUN,   1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b1, 8'hE0));
    vq.push_back(mk(S_IDLE,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'hE0));
    vq.push_back(mk(S_IN,    1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h40, 8'h11, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'hE0));
    vq.push_back(mk(S_RUN,   1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b1, 8'hE0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check8("reset_ptr", ptr, 8'h00);
    check1("reset_wrapped", wrapped, 1'b0);
    check1("reset_conflict", conflict, 1'b0);
    check8("reset_dout", dout, 8'h00);
    rst = 1'b1;
    step();

    // Table-driven vectors: dout checked before the edge, registered state after it
    foreach (vq[i]) begin
      cpustate  = vq[i].cs;
      ld_strobe = vq[i].ld;
      ld_data   = vq[i].ldd;
      chk_step  = vq[i].chk;
      read      = vq[i].rd;
      write     = vq[i].wr;
      addr      = vq[i].a;
      din       = vq[i].d;
      #1;
      check8($sformatf("vec%0d_dout", i), dout, vq[i].exp_dout);
      step();
      check8($sformatf("vec%0d_ptr", i), ptr, vq[i].exp_ptr);
      check1($sformatf("vec%0d_wrapped", i), wrapped, vq[i].exp_wrap);
      check1($sformatf("vec%0d_conflict", i), conflict, vq[i].exp_conf);
      if (vq[i].cd_en) check8($sformatf("vec%0d_chk_data", i), chk_data, vq[i].exp_cd);
    end
    read  = 1'b0;
    write = 1'b0;

    // Pointer wrap across a full 256-byte load
    cpustate = S_IN;
    step();
    for (int i = 0; i < 255; i++) ld_pulse(8'(i));
    check8("wrap_ptr_255", ptr, 8'hFF);
    check1("wrap_not_yet", wrapped, 1'b0);
    ld_pulse(8'hFF);
    check8("wrap_ptr_0", ptr, 8'h00);
    check1("wrap_set", wrapped, 1'b1);
    ld_pulse(8'hC3);
    check8("wrap_257_ptr", ptr, 8'h01);
    check1("wrap_sticky", wrapped, 1'b1);
    check8("wrap_chk_data_1", chk_data, 8'h01);
    cpustate = S_CHECK;
    step();
    check8("wrap_check_ptr", ptr, 8'h00);
    check1("wrap_cleared", wrapped, 1'b0);
    check8("wrap_mem0_overwritten", chk_data, 8'hC3);

    // Reset in the middle of a load
    cpustate = S_IN;
    step();
    for (int i = 0; i < 5; i++) ld_pulse(8'h31 + 8'(i));
    check8("midload_ptr5", ptr, 8'h05);
    check1("midload_conflict_pre", conflict, 1'b1);
    ld_data   = 8'h99;
    ld_strobe = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check8("midload_rst_ptr", ptr, 8'h00);
    check1("midload_rst_wrapped", wrapped, 1'b0);
    check1("midload_rst_conflict", conflict, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    ld_strobe = 1'b0;
    cpustate  = S_CHECK;
    chk_step  = 1'b1;
    step();
    rst = 1'b1;
    step();
    check8("post_rst_ptr_a", ptr, 8'h00);
    step();
    check8("post_rst_level_no_edge", ptr, 8'h00);
    check8("post_rst_mem0", chk_data, 8'h31);
    chk_step = 1'b0;
    step();
    for (int i = 1; i < 6; i++) begin
      chk_pulse();
      check8($sformatf("post_rst_ptr%0d", i), ptr, 8'(i));
      check8($sformatf("post_rst_mem%0d", i), chk_data, (i == 5) ? 8'h05 : 8'h31 + 8'(i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low; one clock domain only.
REQ-003 SHALL have port: cpustate  input  2  CPU state: 00 IDLE, 01 IN (program load), 10 CHECK (readback), 11 RUN.
REQ-004 SHALL have port: addr  input  8  memory address from AR, used in RUN only.
REQ-005 SHALL have port: read  input  1  control-unit read strobe.
REQ-006 SHALL have port: write  input  1  control-unit write strobe.
REQ-007 SHALL have port: din  input  8  bus data to store on write.
REQ-008 SHALL have port: dout  output  8  read data driven toward bus (membus path).
REQ-009 SHALL have port: ld_data  input  8  byte to load in IN state.
REQ-010 SHALL have port: ld_strobe  input  1  load request, level signal from panel; acted on at rising edge only.
REQ-011 SHALL have port: chk_step  input  1  advance readback pointer, level signal; acted on at rising edge only.
REQ-012 SHALL have port: ptr  output  8  current load/check pointer.
REQ-013 SHALL have port: chk_data  output  8  memory content at ptr.
REQ-014 SHALL have port: wrapped  output  1  sticky flag: pointer passed 255->0 in current IN/CHECK session.
REQ-015 SHALL have port: conflict  output  1  sticky flag: read and write asserted in the same RUN cycle.

Function
REQ-016 SHALL contain a 256 x 8 storage array; contents are not cleared by reset.
REQ-017 SHALL register ld_strobe and chk_step each cycle (prev copies, reset to 0) and detect rising edge as current=1 and prev=0.
REQ-018 IN state: on ld_strobe rising edge, SHALL write ld_data to mem[ptr] and increment ptr by 1 in the same clock edge.
REQ-019 CHECK state: on chk_step rising edge, SHALL increment ptr by 1; no memory write.
REQ-020 ptr SHALL wrap 255 -> 0 (8-bit modulo); on that wrap, wrapped SHALL be set and held.
REQ-021 Any change of cpustate (registered previous state differs from current) SHALL clear ptr to 0 and wrapped to 0 on that edge; an edge on ld_strobe/chk_step coinciding with the state change SHALL be ignored.
REQ-022 chk_data SHALL be combinational mem[ptr] in every state.
REQ-023 RUN state, read=1 and write=0: dout SHALL equal mem[addr] combinationally in the same cycle (control samples into DR at the next edge).
REQ-024 dout SHALL be 8'h00 whenever read=0 or cpustate is not RUN.
REQ-025 RUN state, write=1 and read=0: mem[addr] SHALL take din at the rising edge; a read of the same address in the next cycle returns the new value.
REQ-026 RUN state, read=1 and write=1: write SHALL be suppressed, dout SHALL follow REQ-023, conflict SHALL set and remain 1 until reset.
REQ-027 read/write SHALL be ignored outside RUN; ld_strobe ignored outside IN; chk_step ignored outside CHECK.
REQ-028 IDLE state: no memory or pointer change (except REQ-021 clear).

Reset
REQ-029 On rst=0, asynchronously: ptr=0, wrapped=0, conflict=0, edge-detect prev registers=0, previous-cpustate register=00; dout SHALL read 0 because of REQ-024 if state is not RUN.
REQ-030 Reset asserted mid-load SHALL abort without writing the pending byte; memory keeps all previously loaded bytes.
REQ-031 After rst deasserts, first ld_strobe/chk_step edge SHALL be detected only if the strobe goes 0 -> 1 after reset release (level already high at release is not an edge).

Verification
REQ-032 IN, load 8'hE0,8'h10,8'hF0 via three strobe pulses -> ptr=3, mem[0..2]=E0,10,F0; strobe held high 5 cycles produces one write only.
REQ-033 Switch to CHECK -> ptr=0, chk_data=E0; two chk_step pulses -> ptr=2, chk_data=F0.
REQ-034 IN, 256 strobes starting at ptr=0 -> ptr=0, wrapped=1; the 257th strobe overwrites mem[0].
REQ-035 RUN, write=1 addr=8'h40 din=8'h5A, next cycle read=1 addr=8'h40 -> dout=5A same cycle; read=0 -> dout=00.
REQ-036 RUN, read=1 write=1 addr=8'h40 din=8'hFF -> mem[40] stays 5A, dout=5A, conflict=1 until rst low.
REQ-037 rst low during IN with ptr=5 -> ptr=0, wrapped=0, conflict=0 immediately (no clock); mem[0..4] unchanged.
